// File: rtl/mpp_pkg.sv
// Shared types and classification windows for the MPP pattern detector.
package mpp_pkg;

  typedef enum logic [1:0] {
    PAT_NONE     = 2'd0,
    PAT_BEACON   = 2'd1,
    PAT_DIGLF    = 2'd2,
    PAT_PRESSURE = 2'd3
  } pattern_e;

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_CONFIRM = 2'd1,
    ST_LOCKED  = 2'd2
  } fsm_e;

  typedef enum logic [1:0] {
    LVL_UNKNOWN = 2'd0,
    LVL_LOW     = 2'd1,
    LVL_HIGH    = 2'd2
  } level_e;

  localparam int unsigned DIGLF_MIN    = 9;
  localparam int unsigned DIGLF_MAX    = 14;
  localparam int unsigned BEACON_MIN   = 17;
  localparam int unsigned BEACON_MAX   = 23;
  localparam int unsigned PRESSURE_MIN = 24;
  localparam int unsigned PRESSURE_MAX = 30;

  function automatic logic in_win(input int unsigned len, input int unsigned lo,
                                  input int unsigned hi);
    return (len >= lo) && (len <= hi);
  endfunction

  // Both half-periods must fall in the same window; saturated counts never match.
  function automatic pattern_e classify(input int unsigned low_len, input int unsigned high_len);
    if (in_win(low_len, DIGLF_MIN, DIGLF_MAX) && in_win(high_len, DIGLF_MIN, DIGLF_MAX))
      return PAT_DIGLF;
    if (in_win(low_len, BEACON_MIN, BEACON_MAX) && in_win(high_len, BEACON_MIN, BEACON_MAX))
      return PAT_BEACON;
    if (in_win(low_len, PRESSURE_MIN, PRESSURE_MAX) &&
        in_win(high_len, PRESSURE_MIN, PRESSURE_MAX))
      return PAT_PRESSURE;
    return PAT_NONE;
  endfunction

endpackage

// File: rtl/mpp_slicer.sv
// Hysteresis slicer with run-length measurement and dead-band silence detection.
module mpp_slicer
  import mpp_pkg::*;
#(
  parameter int unsigned SAMPLE_W    = 24,
  parameter int unsigned TH          = 1000,
  parameter int unsigned CNT_W       = 6,
  parameter int unsigned SILENCE_LEN = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic signed [SAMPLE_W-1:0] sample_in,
  input  logic                       sample_valid,
  output logic                       rise_c,
  output logic                       silence_c,
  output logic [CNT_W-1:0]           low_len_c,
  output logic [CNT_W-1:0]           high_len,
  output logic                       high_ok
);

  localparam int unsigned DEAD_W = $clog2(SILENCE_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic signed [SAMPLE_W-1:0] TH_P = SAMPLE_W'(TH);
  localparam logic signed [SAMPLE_W-1:0] TH_N = -TH_P;

  level_e              level_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cnt_inc;
  logic [DEAD_W-1:0]   dead_q;
  logic                run_real_q;
  logic                is_high;
  logic                is_low;
  logic                in_band;
  logic                fall_c;

  // Edge and silence decode for the current sample.
  always_comb begin
    is_high   = sample_in >= TH_P;
    is_low    = sample_in <= TH_N;
    in_band   = !is_high && !is_low;
    rise_c    = sample_valid && (level_q == LVL_LOW) && is_high;
    fall_c    = sample_valid && (level_q == LVL_HIGH) && is_low;
    silence_c = sample_valid && in_band && (dead_q == DEAD_W'(SILENCE_LEN - 1));
    low_len_c = cnt_q;
    cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
  end

  // run_real_q marks a run that began at a true edge rather than out of UNKNOWN.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      level_q    <= LVL_UNKNOWN;
      cnt_q      <= '0;
      dead_q     <= '0;
      run_real_q <= 1'b0;
      high_len   <= '0;
      high_ok    <= 1'b0;
    end else if (sample_valid) begin
      cnt_q  <= cnt_inc;
      dead_q <= (in_band && !silence_c) ? dead_q + DEAD_W'(1) : '0;
      if (silence_c) begin
        level_q <= LVL_UNKNOWN;
        high_ok <= 1'b0;
      end else if (level_q == LVL_UNKNOWN && !in_band) begin
        level_q    <= is_high ? LVL_HIGH : LVL_LOW;
        cnt_q      <= CNT_W'(1);
        run_real_q <= 1'b0;
      end else if (fall_c) begin
        level_q    <= LVL_LOW;
        high_len   <= cnt_q;
        high_ok    <= run_real_q;
        run_real_q <= 1'b1;
        cnt_q      <= CNT_W'(1);
      end else if (rise_c) begin
        level_q    <= LVL_HIGH;
        run_real_q <= 1'b1;
        cnt_q      <= CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/mpp_pattern_detector.sv
// Identifies the MPP pattern (Beacon/DigitalLF/Pressure) from the sample stream and tracks lock.
module mpp_pattern_detector
  import mpp_pkg::*;
#(
  parameter int unsigned SAMPLE_W    = 24,
  parameter int unsigned TH          = 1000,
  parameter int unsigned CNT_W       = 6,
  parameter int unsigned CONFIRM     = 2,
  parameter int unsigned SILENCE_LEN = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic signed [SAMPLE_W-1:0] sample_in,
  input  logic                       sample_valid,
  output logic [1:0]                 pattern,
  output logic                       locked,
  output logic                       period_strobe,
  output logic                       mismatch_err
);

  localparam int unsigned CONF_W = $clog2(CONFIRM + 1);

  logic              rise_c;
  logic              silence_c;
  logic [CNT_W-1:0]  low_len_c;
  logic [CNT_W-1:0]  high_len;
  logic              high_ok;
  logic              classify_c;
  pattern_e          cls_c;
  logic [CONF_W-1:0] conf_next_c;

  fsm_e              state_q;
  pattern_e          cand_q;
  logic [CONF_W-1:0] conf_q;

  mpp_slicer #(
    .SAMPLE_W   (SAMPLE_W),
    .TH         (TH),
    .CNT_W      (CNT_W),
    .SILENCE_LEN(SILENCE_LEN)
  ) u_slicer (
    .clk         (clk),
    .rst_n       (rst_n),
    .sample_in   (sample_in),
    .sample_valid(sample_valid),
    .rise_c      (rise_c),
    .silence_c   (silence_c),
    .low_len_c   (low_len_c),
    .high_len    (high_len),
    .high_ok     (high_ok)
  );

  // A period is classified only on a rising edge closing a fully measured high run.
  always_comb begin
    classify_c  = rise_c && high_ok;
    cls_c       = classify(32'(low_len_c), 32'(high_len));
    conf_next_c = (state_q == ST_CONFIRM && cls_c == cand_q) ? conf_q + CONF_W'(1)
                                                             : CONF_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_SEARCH;
      cand_q        <= PAT_NONE;
      conf_q        <= '0;
      pattern       <= '0;
      locked        <= 1'b0;
      period_strobe <= 1'b0;
      mismatch_err  <= 1'b0;
    end else begin
      period_strobe <= 1'b0;
      mismatch_err  <= 1'b0;
      if (silence_c) begin
        state_q <= ST_SEARCH;
        conf_q  <= '0;
        pattern <= '0;
        locked  <= 1'b0;
      end else if (classify_c) begin
        period_strobe <= 1'b1;
        case (state_q)
          ST_SEARCH, ST_CONFIRM: begin
            if (cls_c == PAT_NONE) begin
              state_q <= ST_SEARCH;
              conf_q  <= '0;
            end else begin
              cand_q <= cls_c;
              conf_q <= conf_next_c;
              if (conf_next_c == CONF_W'(CONFIRM)) begin
                state_q <= ST_LOCKED;
                pattern <= cls_c;
                locked  <= 1'b1;
              end else begin
                state_q <= ST_CONFIRM;
              end
            end
          end
          ST_LOCKED: begin
            if (cls_c != cand_q) begin
              state_q      <= ST_SEARCH;
              conf_q       <= '0;
              pattern      <= '0;
              locked       <= 1'b0;
              mismatch_err <= 1'b1;
            end
          end
          default: state_q <= ST_SEARCH;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mpp_pattern_detector.sv
// Directed MPP loops plus randomized run-length stimulus against a sample-index reference model.
module tb_mpp_pattern_detector;

  localparam int TH          = 1000;
  localparam int CONFIRM     = 2;
  localparam int SILENCE_LEN = 64;
  localparam int CNT_MAX     = 63;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] sample_in = '0;
  logic        sample_valid = 1'b0;
  logic [1:0]  pattern;
  logic        locked;
  logic        period_strobe;
  logic        mismatch_err;

  always #5 clk = ~clk;

  mpp_pattern_detector #(
    .SAMPLE_W(24), .TH(1000), .CNT_W(6), .CONFIRM(2), .SILENCE_LEN(64)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .pattern      (pattern),
    .locked       (locked),
    .period_strobe(period_strobe),
    .mismatch_err (mismatch_err)
  );

  int total = 0;
  int bad = 0;
  int err_seen = 0;

  // Reference model: runs measured as differences of accepted-sample indices.
  int m_lvl;        // 0 unknown, 1 low, 2 high
  int m_idx;
  int m_run_start;
  bit m_run_real;
  bit m_hok;
  int m_hl;
  int m_dead;
  int m_cls;
  int m_streak;     // consecutive identical matches since the last break
  int e_pat;
  bit e_lock;
  bit e_strb;
  bit e_err;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int ref_class(input int lo, input int hi);
    if (lo >= 9 && lo <= 14 && hi >= 9 && hi <= 14) return 2;
    if (lo >= 17 && lo <= 23 && hi >= 17 && hi <= 23) return 1;
    if (lo >= 24 && lo <= 30 && hi >= 24 && hi <= 30) return 3;
    return 0;
  endfunction

  task automatic model_reset();
    m_lvl = 0; m_idx = 0; m_run_start = 0; m_run_real = 0; m_hok = 0; m_hl = 0;
    m_dead = 0; m_cls = 0; m_streak = 0;
    e_pat = 0; e_lock = 0; e_strb = 0; e_err = 0;
  endtask

  task automatic model_period(input int c);
    e_strb = 1;
    if (m_streak >= CONFIRM) begin
      if (c != m_cls) begin
        e_err = 1; m_streak = 0; e_pat = 0; e_lock = 0;
      end else begin
        m_streak++;
      end
    end else if (c == 0) begin
      m_streak = 0;
    end else if (m_streak > 0 && c == m_cls) begin
      m_streak++;
    end else begin
      m_cls = c; m_streak = 1;
    end
    if (m_streak >= CONFIRM) begin
      e_pat = m_cls; e_lock = 1;
    end
  endtask

  task automatic model_accept(input int s);
    int lv;
    int lo;
    e_strb = 0; e_err = 0;
    lv = (s >= TH) ? 2 : (s <= -TH) ? 1 : m_lvl;
    if (s > -TH && s < TH) m_dead++; else m_dead = 0;
    if (m_dead == SILENCE_LEN) begin
      m_dead = 0; m_lvl = 0; m_hok = 0; m_streak = 0; e_pat = 0; e_lock = 0;
    end else if (m_lvl == 0 && lv != 0) begin
      m_lvl = lv; m_run_start = m_idx; m_run_real = 0;
    end else if (m_lvl == 2 && lv == 1) begin
      m_hl = min_i(m_idx - m_run_start, CNT_MAX);
      m_hok = m_run_real; m_run_real = 1; m_run_start = m_idx; m_lvl = 1;
    end else if (m_lvl == 1 && lv == 2) begin
      lo = min_i(m_idx - m_run_start, CNT_MAX);
      m_run_real = 1; m_run_start = m_idx; m_lvl = 2;
      if (m_hok) model_period(ref_class(lo, m_hl));
    end
    m_idx++;
  endtask

  task automatic drive(input int s, input bit v);
    sample_in = 24'(s);
    sample_valid = v;
    @(posedge clk);
    #1;
    if (!rst_n) model_reset();
    else if (v) model_accept(s);
    else begin e_strb = 0; e_err = 0; end
    check("pattern", int'(pattern), e_pat);
    check("locked", int'(locked), int'(e_lock));
    check("period_strobe", int'(period_strobe), int'(e_strb));
    check("mismatch_err", int'(mismatch_err), int'(e_err));
    if (mismatch_err) err_seen++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1920, 1'b1);
    rst_n = 1'b1;
  endtask

  function automatic int beacon_s(input int i);
    case (i)
      8: return 1580;   9: return 798;   10: return -3;  11: return -804; 12: return -1585;
      28: return -1577; 29: return -798; 30: return 3;   31: return 804;  32: return 1585;
      default: return (i >= 13 && i <= 27) ? -1920 : 1920;
    endcase
  endfunction

  function automatic int diglf_s(input int i);
    case (i)
      4: return 1100;   5: return -300;  6: return -1600;
      15: return -1600; 16: return -300; 17: return 1100;
      default: return (i >= 7 && i <= 14) ? -1920 : 1920;
    endcase
  endfunction

  function automatic int pressure_s(input int i);
    case (i)
      13: return 900;  14: return -200; 15: return -1500;
      38: return -900; 39: return 200;  40: return 800;  41: return 1500;
      default: return (i >= 16 && i <= 37) ? -1920 : 1920;
    endcase
  endfunction

  function automatic int rand_deadband();
    return int'($urandom_range(0, 1998)) - 999;
  endfunction

  // Accepted sample preceded by an occasional stall cycle carrying junk.
  task automatic feed(input int s);
    if ($urandom_range(0, 7) == 0) drive(int'($urandom_range(0, 4000)) - 2000, 1'b0);
    drive(s, 1'b1);
  endtask

  task automatic emit_run(input int sgn, input int n);
    int mag;
    for (int k = 0; k < n; k++) begin
      case ($urandom_range(0, 3))
        0: mag = TH;
        1: mag = TH + 1;
        2: mag = 1920;
        default: mag = int'($urandom_range(1000, 8388607));
      endcase
      if (k > 0 && $urandom_range(0, 5) == 0) feed(rand_deadband());
      else feed(sgn * mag);
    end
  endtask

  function automatic int pick_len(input int pool);
    case (pool)
      1: return int'($urandom_range(16, 24));
      2: return int'($urandom_range(8, 15));
      3: return int'($urandom_range(23, 31));
      default: return int'($urandom_range(1, 70));
    endcase
  endfunction

  initial begin
    int err_before;
    int lo;
    int hi;
    model_reset();
    do_reset();

    // Beacon loop: partial first period, first classification at 72, lock at 112.
    for (int i = 0; i < 160; i++) begin
      drive(beacon_s(i % 40), 1'b1);
      if (i == 32)  check("beacon_partial_no_strobe", int'(period_strobe), 0);
      if (i == 72)  check("beacon_first_strobe", int'(period_strobe), 1);
      if (i == 111) check("beacon_prelock", int'(locked), 0);
      if (i == 112) check("beacon_lock_pat", int'(pattern), 1);
      if (i == 112) check("beacon_lock", int'(locked), 1);
    end

    // Switch to DigitalLF at a loop boundary: one mismatch, then relock.
    err_before = err_seen;
    for (int j = 0; j < 138; j++) begin
      drive(diglf_s(j % 23), 1'b1);
      if (j == 17) check("switch_mismatch", int'(mismatch_err), 1);
      if (j == 17) check("switch_pat_cleared", int'(pattern), 0);
      if (j == 63) check("diglf_relock", int'(pattern), 2);
    end
    check("switch_err_count", err_seen - err_before, 1);

    // Pressure with a mid-stream stall, then silence.
    do_reset();
    for (int i = 0; i < 208; i++) begin
      if (i == 160) for (int k = 0; k < 100; k++) drive(int'($urandom_range(0, 4000)) - 2000, 1'b0);
      drive(pressure_s(i % 52), 1'b1);
      if (i == 144) check("pressure_prelock", int'(pattern), 0);
      if (i == 145) check("pressure_lock", int'(pattern), 3);
    end
    check("pressure_after_stall", int'(pattern), 3);
    err_before = err_seen;
    for (int k = 0; k < 64; k++) begin
      drive(0, 1'b1);
      if (k == 62) check("silence_not_yet", int'(locked), 1);
      if (k == 63) check("silence_pat", int'(pattern), 0);
      if (k == 63) check("silence_unlock", int'(locked), 0);
    end
    check("silence_no_err", err_seen - err_before, 0);

    // Reset while locked: first run after reset is partial.
    do_reset();
    for (int i = 0; i < 120; i++) drive(beacon_s(i % 40), 1'b1);
    check("relocked_before_reset", int'(locked), 1);
    do_reset();
    for (int j = 0; j < 100; j++) begin
      drive(beacon_s((20 + j) % 40), 1'b1);
      if (j == 12) check("post_reset_partial", int'(period_strobe), 0);
      if (j == 91) check("post_reset_prelock", int'(locked), 0);
      if (j == 92) check("post_reset_lock", int'(pattern), 1);
    end

    // Randomized run lengths around every window boundary, silences and resets.
    for (int blk = 0; blk < 60; blk++) begin
      case ($urandom_range(0, 11))
        0: for (int k = 0; k < int'($urandom_range(50, 80)); k++) feed(rand_deadband());
        1: do_reset();
        default: begin
          lo = pick_len(int'($urandom_range(0, 3)));
          hi = pick_len(int'($urandom_range(0, 5)) > 1 ? 0 : 0);
          hi = ($urandom_range(0, 3) == 0) ? hi : lo + int'($urandom_range(0, 2)) - 1;
          if (hi < 1) hi = 1;
          for (int p = 0; p < int'($urandom_range(1, 5)); p++) begin
            emit_run(1, hi);
            emit_run(-1, lo);
          end
        end
      endcase
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mpp_pattern_detector.md
Name: mpp_pattern_detector

Overview:
- Receive-side counterpart of the MPP waveform generator. Consumes the 24-bit signed MPP sample stream and works out which pattern is being sent: Beacon, DigitalLF or Pressure.
- Signal path: hysteresis slicer, then low/high run-length measurement, then period classification, then a lock state machine.
- Sits at the output of the MPP signal path and feeds status logic. It is also the self-check monitor for generator benches.

Parameters:
- SAMPLE_W, 24, sample width (signed).
- TH, 1000, hysteresis threshold magnitude in LSB.
- CNT_W, 6, run-counter width; counters saturate at 2^CNT_W-1.
- CONFIRM, 2, consecutive matching periods needed to lock.
- SILENCE_LEN, 64, consecutive dead-band samples that declare silence.

Ports:
- clk, in, 1, rising-edge clock.
- rst_n, in, 1, synchronous active-low reset.
- sample_in, in, SAMPLE_W, signed MPP sample.
- sample_valid, in, 1, qualifies sample_in; when low, all state holds.
- pattern, out, 2, 0=NONE, 1=BEACON, 2=DIGLF, 3=PRESSURE.
- locked, out, 1, high while pattern is confirmed.
- period_strobe, out, 1, one-cycle pulse on each classified rising edge.
- mismatch_err, out, 1, one-cycle pulse when a locked pattern is lost through a mismatch.

Behaviour:
- Reset and clocking
  - One clock. Reset is synchronous, active-low, and dominates all other inputs.
  - Reset values: pattern=0, locked=0, period_strobe=0, mismatch_err=0, slicer=UNKNOWN, all counters 0, FSM=SEARCH.
  - Asserting reset mid-operation discards any partial runs.
  - All outputs are registered and update the cycle after the accepted sample that causes the change.
- Slicer (accepted samples only)
  - sample >= TH goes to HIGH. sample <= -TH goes to LOW. Otherwise the level holds.
  - From UNKNOWN, the first qualifying sample sets the level with no edge recorded. The run it starts is partial and never classified.
- Run counters
  - The run counter increments on every accepted sample and saturates.
  - HIGH->LOW: store high_len = count and set high_ok (only if that run began at a real edge). Restart count at 1.
  - LOW->HIGH: low_len = count, restart count at 1, then classify.
- Classification (at LOW->HIGH only, requires high_ok)
  - DIGLF: low_len 9..14 and high_len 9..14 (nominal 11/12).
  - BEACON: low_len 17..23 and high_len 17..23 (nominal 20/20).
  - PRESSURE: low_len 24..30 and high_len 24..30 (nominal 26/26).
  - Anything else, including saturated counts, is NOMATCH.
  - period_strobe pulses for every classification, NOMATCH included.
- FSM: SEARCH, CONFIRM, LOCKED.
  - SEARCH: a match sets cand=class, cnt=1, and goes to CONFIRM (or straight to LOCKED if CONFIRM==1).
  - CONFIRM: same class increments cnt; at cnt==CONFIRM go to LOCKED, pattern=cand, locked=1. A different match restarts with cand=new class, cnt=1. NOMATCH returns to SEARCH.
  - LOCKED: same class stays. Any other result (different class or NOMATCH) gives mismatch_err pulse, pattern=0, locked=0, SEARCH.
- Silence
  - |sample| < TH for SILENCE_LEN consecutive accepted samples: slicer=UNKNOWN, high_ok=0, FSM=SEARCH, pattern=0, locked=0. No mismatch_err.
  - The dead-band counter clears on any sample outside the band.
- Simultaneous events: silence expiry on the same sample as an edge cannot occur (an edge needs |sample|>=TH). Reset beats everything.

Decomposition:
- Package mpp_pkg:
  - pattern enum (NONE, BEACON, DIGLF, PRESSURE).
  - FSM state enum.
  - Classification window min/max constants for each pattern.
- Sub-module mpp_slicer: hysteresis slicer plus run counter, the high_ok/partial tracking, and the dead-band silence counter.
  - Outputs: rise/fall strobes, low_len, high_len, high_ok, silence.

Test Plan:
- Beacon loop (40-sample table: 1920 x8, 1580, 798, -3, -804, -1585, -1920 x15, -1577, -798, 3, 804, 1585, 1920 x7), sample_valid=1 from sample 0, repeated:
  - First falling edge at sample 12, low_len=20 at samples 32/72/112.
  - First classification at sample 72, lock at sample 112: pattern=1 and locked=1 one cycle later.
- DigitalLF 23-sample loop (1920 x4, 1100, -300, -1600, -1920 x8, -1600, -300, 1100, 1920 x5): low=11, high=12; pattern=2 after the second classified period (sample 63).
- Pressure 52-sample loop: low=26, high=26; pattern=3 locked after the second classified period (sample 145).
- Beacon locked, then switch to the DigitalLF loop at a period boundary: next classification gives mismatch_err pulse, pattern=0, then relock to 2 after 2 further DIGLF periods.
- Locked Pressure, then hold sample_in=0: after 64 samples pattern=0, locked=0, mismatch_err never pulses. Stalling sample_valid=0 for 100 cycles mid-stream changes nothing.
- Assert rst_n=0 for 1 cycle while locked: all outputs 0 next cycle, the first post-reset run is partial, and relock needs the full count again.
